glay_control_chain_sync: RTL
============================

# glay_control_chain_sync

Kernel-level control synchronizer for the ap_ctrl_chain protocol. Sits between the host control register interface, which produces start/continue/setup, and the GLay engine.
- Registers the host control inputs and sequences them through a Moore FSM.
- Produces the ready/done/idle/enable control outputs consumed by the host side and the engine.
- Measures busy cycles per run.

## Interface
Parameters:
- CYCLE_COUNTER_WIDTH, 32, width of busy-cycle counter (≥2)

Ports:
- ap_clk  in  1  kernel clock, all logic on rising edge
- ap_rst_n  in  1  reset; synchronous and active-low
- control_in  in  3  GlayControlChainInterfaceInput {glay_start, glay_continue, glay_setup}, levels from host control
- control_out  out  4  GlayControlChainInterfaceOutput {glay_ready, glay_done, glay_idle, glay_enable}
- setup_done_in  in  1  engine finished configuration (level)
- engine_done_in  in  1  engine finished current run (level, held until glay_enable drops)
- fsm_state_out  out  3  current state encoding, for debug
- busy_cycles_out  out  CYCLE_COUNTER_WIDTH  cycles spent in BUSY during the last or current run

## Operation
- Input stage: control_in is captured every cycle into control_in_reg. The FSM reacts only to control_in_reg. setup_done_in and engine_done_in are used unregistered.
- State encoding: RESET=0, IDLE=1, SETUP=2, READY=3, START=4, BUSY=5, DONE=6. fsm_state_out equals the state register.
- Transitions:
  - RESET → IDLE: first cycle with ap_rst_n=1.
  - IDLE → SETUP: glay_setup_reg=1. glay_start_reg in IDLE is ignored, so a start without setup never launches the engine.
  - SETUP → READY: setup_done_in=1.
  - READY → START: glay_start_reg=1.
  - START → BUSY: unconditional; START lasts exactly 1 cycle.
  - BUSY → DONE: engine_done_in=1.
  - DONE → READY: glay_continue_reg=1. No new setup is needed for back-to-back runs.
- Outputs are decoded from the state register only (Moore, glitch-free):
  - glay_idle=1 in IDLE, SETUP and READY.
  - glay_ready=1 in START only (1-cycle pulse: start accepted).
  - glay_enable=1 in START and BUSY.
  - glay_done=1 in DONE, held until continue is seen.
  - All outputs are 0 in RESET.
- Busy counter:
  - Cleared to 0 in START.
  - +1 each cycle in BUSY, saturating at 2^CYCLE_COUNTER_WIDTH−1 with no wrap.
  - Holds its value in all other states until the next START.
- Sampling windows: setup_done_in is sampled only in SETUP and engine_done_in only in BUSY. Assertions in any other state are ignored.
- Simultaneous events:
  - start and continue both high in DONE: continue is honoured (→ READY). Because start is a level, READY → START follows on the next cycle.
  - setup held high in READY/DONE has no effect.

## Timing
- Reset: ap_rst_n=0 at any edge, including mid-BUSY or mid-DONE, forces state RESET on that edge. The same edge clears control_in_reg, busy_cycles_out and control_out to 0, and fsm_state_out to 0.
- Start latency: glay_start sampled at edge N → control_in_reg at N → START at N+1. glay_ready and glay_enable are visible after N+1 (2 edges from input to output).
- Continue latency: glay_continue sampled at edge N → READY at N+1, so glay_done drops after N+1.
- Done latency: engine_done_in high before edge M while in BUSY → DONE at M. glay_enable drops and glay_done rises after M.
- Busy count: a run with K cycles in BUSY reports busy_cycles_out=K, given no saturation.
- No combinational path from any input to any output.

## Test plan
- Reset values: hold ap_rst_n=0 for 3 cycles with random control_in → control_out=4'b0000, fsm_state_out=0, busy_cycles_out=0. The first cycle after release gives state 1 and glay_idle=1.
- Full run: setup → setup_done 2 cycles later → start → engine_done after BUSY has lasted 10 cycles → continue. Required response:
  - States follow 1,2,3,4,5,6,3.
  - glay_ready is a single-cycle pulse.
  - busy_cycles_out=10.
  - glay_done stays high until 2 edges after continue is driven.
- Start without setup: in IDLE, hold glay_start=1 for 20 cycles → state stays 1, glay_enable never asserts.
- Back-to-back: in DONE, assert continue and start together → DONE→READY→START on consecutive edges, and busy_cycles_out clears to 0 in START.
- Saturation: with CYCLE_COUNTER_WIDTH=4, stay in BUSY for 20 cycles → busy_cycles_out=15, held through DONE.
- Reset mid-operation: drop ap_rst_n for 1 cycle while in BUSY with busy_cycles_out=7 → next state RESET, all outputs 0, counter 0, then IDLE. A following start without setup is ignored.

Source files
------------

// File: rtl/glay_control_chain_sync.sv
// ap_ctrl_chain control synchronizer: registers host start/continue/setup levels,
// sequences them through a Moore FSM and counts busy cycles per engine run.
module glay_control_chain_sync #(
    parameter int CYCLE_COUNTER_WIDTH = 32
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic [2:0]                     control_in,
    output logic [3:0]                     control_out,
    input  logic                           setup_done_in,
    input  logic                           engine_done_in,
    output logic [2:0]                     fsm_state_out,
    output logic [CYCLE_COUNTER_WIDTH-1:0] busy_cycles_out
);

    typedef struct packed {
        logic glay_start;
        logic glay_continue;
        logic glay_setup;
    } ctrl_in_t;

    typedef struct packed {
        logic glay_ready;
        logic glay_done;
        logic glay_idle;
        logic glay_enable;
    } ctrl_out_t;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_IDLE  = 3'd1,
        S_SETUP = 3'd2,
        S_READY = 3'd3,
        S_START = 3'd4,
        S_BUSY  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [CYCLE_COUNTER_WIDTH-1:0] CNT_MAX = '1;

    state_t                         state, state_nxt;
    ctrl_in_t                       control_in_reg;
    ctrl_out_t                      ctrl_q;
    logic [CYCLE_COUNTER_WIDTH-1:0] busy_cnt;

    // Outputs are decoded from the next state and registered, so they line up
    // with the state register without any input-to-output combinational path.
    function automatic ctrl_out_t decode(input state_t s);
        ctrl_out_t o;
        o             = '0;
        o.glay_idle   = (s == S_IDLE) || (s == S_SETUP) || (s == S_READY);
        o.glay_ready  = (s == S_START);
        o.glay_enable = (s == S_START) || (s == S_BUSY);
        o.glay_done   = (s == S_DONE);
        return o;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET: state_nxt = S_IDLE;
            S_IDLE:  if (control_in_reg.glay_setup)    state_nxt = S_SETUP;
            S_SETUP: if (setup_done_in)                state_nxt = S_READY;
            S_READY: if (control_in_reg.glay_start)    state_nxt = S_START;
            S_START: state_nxt = S_BUSY;
            S_BUSY:  if (engine_done_in)               state_nxt = S_DONE;
            S_DONE:  if (control_in_reg.glay_continue) state_nxt = S_READY;
            default: state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state          <= S_RESET;
            control_in_reg <= '0;
            ctrl_q         <= '0;
            busy_cnt       <= '0;
        end else begin
            control_in_reg <= control_in;
            state          <= state_nxt;
            ctrl_q         <= decode(state_nxt);
            // Counter reads 0 while in START, then counts each completed BUSY cycle.
            if (state_nxt == S_START)
                busy_cnt <= '0;
            else if (state == S_BUSY && busy_cnt != CNT_MAX)
                busy_cnt <= busy_cnt + 1'b1;
        end
    end

    assign control_out     = ctrl_q;
    assign fsm_state_out   = state;
    assign busy_cycles_out = busy_cnt;

endmodule
